// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: fetch PC, req/ack memory port, instruction buffer, redirects.
// Optional IFU_BYPASS_EN: forward an ack straight to decode when the buffer is empty.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     buf_data_q [FIFO_DEPTH];
  logic [31:0]     buf_pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     hold_data_q, hold_pc_q;
  logic            fifo_empty, bypass, push, pop;
  logic [31:0]     target, pc_inc;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign pc_inc     = pc_q + 32'd4;
  assign fifo_empty = (count_q == '0);

`ifdef IFU_BYPASS_EN
  assign bypass = fifo_empty && (state_q == StReq) && imem_ack && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !fifo_empty || bypass;
  assign inst_data  = bypass ? imem_rdata : (!fifo_empty ? buf_data_q[rd_ptr_q] : hold_data_q);
  assign inst_pc    = bypass ? imem_addr  : (!fifo_empty ? buf_pc_q[rd_ptr_q]   : hold_pc_q);

  // A redirect flushes the buffer, so any pop or push in that cycle is void.
  assign pop  = !fifo_empty && inst_ready && !redirect_valid;
  assign push = (state_q == StReq) && imem_ack && !redirect_valid && !(bypass && inst_ready);

  assign imem_req  = (state_q == StReq) || (state_q == StDrop);
  assign imem_addr = addr_q;
  assign fetch_pc  = pc_q;

  always_comb begin
    count_d = count_q;
    if (redirect_valid) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          pc_d    = target;
          addr_d  = target;
          state_d = StReq;
        end else if (count_q < DepthC) begin
          addr_d  = pc_q;
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect_valid) begin
          pc_d = target;
          if (imem_ack) begin
            addr_d  = target;
            state_d = StReq;
          end else begin
            // Request already on the bus; swallow its data before refetching.
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (count_d < DepthC) begin
            addr_d  = pc_inc;
            state_d = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (redirect_valid) begin
          pc_d = target;
        end
        if (imem_ack) begin
          addr_d  = pc_d;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      if (inst_valid) begin
        hold_data_q <= inst_data;
        hold_pc_q   <= inst_pc;
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          buf_data_q[wr_ptr_q] <= imem_rdata;
          buf_pc_q[wr_ptr_q]   <= pc_q;
          wr_ptr_q             <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: the expected instruction stream is the
// sequential PC walk from reset or the last redirect target, with data from a memory function.
module tb_inst_fetch_unit;

`ifdef IFU_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fetch_pc      (fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  item_t       sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  bit          drop_pending;
  bit          prev_pending;
  logic [31:0] prev_addr;
  int          q_pre;
  bit          bcond;
  bit          started;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    started        = 1'b0;
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    sb_q.delete();
    m_pc           = 32'h0;
    drop_pending   = 1'b0;
    prev_pending   = 1'b0;
    q_pre          = 0;
    bcond          = 1'b0;
    @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;
  endtask

  // One cycle of stimulus, applied at the falling edge; the model is updated alongside.
  task automatic drive(input bit rdy, input bit ackw, input bit rd, input logic [31:0] tgt);
    bit a;
    @(negedge clk);
    chk("fetch_pc", fetch_pc, m_pc);
    if (prev_pending) begin
      chk("req_held", {31'b0, imem_req}, 32'h1);
      chk("addr_held", imem_addr, prev_addr);
    end
    a              = ackw && imem_req;
    inst_ready     = rdy;
    imem_ack       = a;
    imem_rdata     = a ? memf(imem_addr) : $urandom;
    redirect_valid = rd;
    redirect_pc    = tgt;
    q_pre          = sb_q.size();
    bcond          = a && !rd && !drop_pending && (q_pre == 0);
    if (a && !drop_pending && !rd) begin
      chk("ack_addr", imem_addr, m_pc);
      sb_q.push_back('{pc: m_pc, data: memf(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (a) drop_pending = 1'b0;
    if (rd) begin
      sb_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      if (imem_req && !a) drop_pending = 1'b1;
    end
    prev_pending = imem_req && !a;
    prev_addr    = imem_addr;
  endtask

  initial begin : monitor
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (started) begin
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, (q_pre != 0) || (Byp && bcond)});
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (sb_q.size() == 0) begin
            chk("pop_nonempty", 32'h0, 32'h1);
          end else begin
            e = sb_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_data", inst_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b1;
    do_reset();
    // Streaming fetch with immediate acks.
    repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

    // Decode stalled: buffer fills to depth and fetch stops at 0x8.
    do_reset();
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("full_req_low", {31'b0, imem_req}, 32'h0);
    chk("full_fetch_pc", fetch_pc, 32'h8);
    chk("full_valid", {31'b0, inst_valid}, 32'h1);
    repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

    // Slow memory: ack after three wait cycles.
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);

    // Redirect while a request is outstanding.
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    repeat (6) drive(1'b1, 1'b1, 1'b0, '0);

    // Redirect coinciding with pop and ack.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (4) drive(1'b1, 1'b1, 1'b0, '0);

    // Address wrap at the top of memory.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF7);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);
    repeat (4) drive(1'b1, 1'b1, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, t);
    end
    repeat (6) drive(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
